// File: rtl/loader_pkg.sv
// Shared definitions for the boot-time program loader.
//
// Contents:
//   loader_state_t  - loader FSM states (HDR, DATA, CSUM, DONE, ERR)
//   BYTES_PER_WORD  - bytes assembled into one instruction word
//   ADDR_STEP       - byte-address increment between consecutive words
package loader_pkg;

    typedef enum logic [2:0] {
        HDR  = 3'd0,
        DATA = 3'd1,
        CSUM = 3'd2,
        DONE = 3'd3,
        ERR  = 3'd4
    } loader_state_t;

    localparam int          BYTES_PER_WORD = 4;
    localparam logic [31:0] ADDR_STEP      = 32'd4;

endpackage

// File: rtl/byte_assembler.sv
// Little-endian byte-to-word assembler shared by the header, data and
// checksum phases of the program loader.
//
// Ports:
//   clk         in   clock
//   rstn        in   asynchronous active-low reset
//   rx_byte     in   [7:0] incoming byte
//   accept      in   byte is consumed this cycle
//   clear       in   drop any partially assembled word
//   word        out  [31:0] word including the byte presented this cycle
//   word_valid  out  this cycle's accepted byte completes a word
//
// word/word_valid are combinational from the current byte so the parent can
// register the completed word on the same edge that accepts its last byte.
module byte_assembler
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic [7:0]  rx_byte,
    input  logic        accept,
    input  logic        clear,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [1:0]  byte_cnt_reg;
    logic [31:0] shift_reg;
    logic        last_byte;

    // First byte received ends up in bits [7:0] after four shifts.
    assign word       = {rx_byte, shift_reg[31:8]};
    assign last_byte  = (byte_cnt_reg == 2'(BYTES_PER_WORD - 1));
    assign word_valid = accept && last_byte;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            byte_cnt_reg <= 2'd0;
            shift_reg    <= 32'd0;
        end else if (clear) begin
            byte_cnt_reg <= 2'd0;
        end else if (accept) begin
            shift_reg    <= word;
            byte_cnt_reg <= byte_cnt_reg + 2'd1;
        end
    end

endmodule

// File: rtl/program_loader.sv
// Boot-time instruction-memory writer. Receives the program image as a UART
// byte stream: a 4-byte little-endian word count N, then N little-endian
// data words, optionally followed by a 4-byte checksum trailer. Each data
// word is written to instruction memory at byte address 4*index.
//
// Optional feature macro: PROGRAM_LOADER_CHECKSUM_EN
//   defined   - a 4-byte trailer holding the 32-bit wrap-around sum of the
//               data words is expected and checked
//   undefined - no trailer; the last data word (or an N==0 header) ends the load
//
// Ports:
//   clk          in   clock
//   rstn         in   asynchronous active-low reset
//   rx_data      in   [7:0]  byte from UART receiver
//   rx_valid     in   rx_data valid
//   rx_ready     out  loader accepts a byte (HDR/DATA/CSUM)
//   pro_addr     out  [31:0] byte address of the word being written
//   pro_data     out  [31:0] instruction word being written
//   memwrite     out  one-cycle write strobe
//   load_done    out  image loaded without error (sticky)
//   load_error   out  header count or checksum failed (sticky)
//   words_loaded out  [31:0] words written so far
module program_loader
    import loader_pkg::*;
#(
    parameter int MAX_WORDS = 23001
)
(
    input  logic        clk,
    input  logic        rstn,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [31:0] pro_addr,
    output logic [31:0] pro_data,
    output logic        memwrite,
    output logic        load_done,
    output logic        load_error,
    output logic [31:0] words_loaded
);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    localparam loader_state_t AFTER_DATA = CSUM;
`else
    localparam loader_state_t AFTER_DATA = DONE;
`endif

    loader_state_t state_reg, state_next;

    logic [31:0] count_reg;
    logic [31:0] words_loaded_reg;
    logic [31:0] pro_addr_reg;
    logic [31:0] pro_data_reg;
    logic        memwrite_reg;

    logic        accept;
    logic        asm_clear;
    logic [31:0] asm_word;
    logic        word_valid;
    logic        last_word;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [31:0] sum_reg;
`endif

    assign rx_ready  = (state_reg == HDR) || (state_reg == DATA) || (state_reg == CSUM);
    assign accept    = rx_valid && rx_ready;
    assign asm_clear = (state_reg == DONE) || (state_reg == ERR);
    // words_loaded_reg doubles as the index of the word being completed.
    assign last_word = ((words_loaded_reg + 32'd1) == count_reg);

    byte_assembler u_asm (
        .clk        (clk),
        .rstn       (rstn),
        .rx_byte    (rx_data),
        .accept     (accept),
        .clear      (asm_clear),
        .word       (asm_word),
        .word_valid (word_valid)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg <= HDR;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            HDR: begin
                if (word_valid) begin
                    if (asm_word > 32'(MAX_WORDS)) begin
                        state_next = ERR;
                    end else if (asm_word == 32'd0) begin
                        state_next = AFTER_DATA;
                    end else begin
                        state_next = DATA;
                    end
                end
            end
            DATA: begin
                if (word_valid && last_word) begin
                    state_next = AFTER_DATA;
                end
            end
            CSUM: begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                if (word_valid) begin
                    state_next = (asm_word == sum_reg) ? DONE : ERR;
                end
`else
                state_next = ERR;
`endif
            end
            default: state_next = state_reg;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_reg        <= 32'd0;
            words_loaded_reg <= 32'd0;
            pro_addr_reg     <= 32'd0;
            pro_data_reg     <= 32'd0;
            memwrite_reg     <= 1'b0;
        end else begin
            memwrite_reg <= 1'b0;
            if ((state_reg == HDR) && word_valid) begin
                count_reg <= asm_word;
            end
            if ((state_reg == DATA) && word_valid) begin
                pro_addr_reg     <= words_loaded_reg * ADDR_STEP;
                pro_data_reg     <= asm_word;
                memwrite_reg     <= 1'b1;
                words_loaded_reg <= words_loaded_reg + 32'd1;
            end
        end
    end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sum_reg <= 32'd0;
        end else if ((state_reg == DATA) && word_valid) begin
            sum_reg <= sum_reg + asm_word;
        end
    end
`endif

    assign pro_addr     = pro_addr_reg;
    assign pro_data     = pro_data_reg;
    assign memwrite     = memwrite_reg;
    assign words_loaded = words_loaded_reg;
    assign load_done    = (state_reg == DONE);
    assign load_error   = (state_reg == ERR);

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader. Stimulus tasks build byte images,
// a stream-level reference model turns each image into the list of expected
// memory writes plus final flags, and a monitor pops/compares on memwrite.
module tb_program_loader;

    localparam int MAX_W = 23001;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    logic        clk;
    logic        rstn;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [31:0] pro_addr;
    logic [31:0] pro_data;
    logic        memwrite;
    logic        load_done;
    logic        load_error;
    logic [31:0] words_loaded;

    program_loader #(.MAX_WORDS(MAX_W)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .pro_addr     (pro_addr),
        .pro_data     (pro_data),
        .memwrite     (memwrite),
        .load_done    (load_done),
        .load_error   (load_error),
        .words_loaded (words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] wl;
    } wr_t;

    wr_t         exp_q[$];
    logic [7:0]  img[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    bit          spacing_en = 1'b0;
    bit          have_prev = 1'b0;
    int          prev_cyc = 0;
    bit          exp_done;
    bit          exp_err;
    logic [31:0] exp_words;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the next expected write.
    always @(negedge clk) begin : monitor
        wr_t e;
        if (rstn && memwrite === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: got addr %h data %h required no write", pro_addr, pro_data);
            end else begin
                e = exp_q.pop_front();
                chk("write_addr", pro_addr, e.addr);
                chk("write_data", pro_data, e.data);
                chk("write_count", words_loaded, e.wl);
            end
            if (spacing_en) begin
                if (have_prev) chk("write_spacing", 32'(cyc - prev_cyc), 32'd4);
                have_prev = 1'b1;
                prev_cyc  = cyc;
            end
        end
    end

    // Reference model: interprets the byte stream by the image format rules.
    task automatic model(input logic [7:0] q[$]);
        logic [31:0] n, w, sum;
        wr_t e;
        exp_done = 1'b0;
        exp_err = 1'b0;
        exp_words = 32'd0;
        sum = 32'd0;
        if (q.size() < 4) return;
        n = {q[3], q[2], q[1], q[0]};
        if (n > 32'(MAX_W)) begin
            exp_err = 1'b1;
            return;
        end
        for (int k = 0; k < int'(n); k++) begin
            if (q.size() < 4 * k + 8) return;
            w = {q[4*k+7], q[4*k+6], q[4*k+5], q[4*k+4]};
            e.addr = 32'(4 * k);
            e.data = w;
            e.wl   = 32'(k + 1);
            exp_q.push_back(e);
            sum = sum + w;
            exp_words = 32'(k + 1);
        end
        if (CSUM_EN) begin
            if (q.size() < 4 * int'(n) + 8) return;
            w = {q[4*n+7], q[4*n+6], q[4*n+5], q[4*n+4]};
            if (w == sum) exp_done = 1'b1;
            else exp_err = 1'b1;
        end else begin
            exp_done = 1'b1;
        end
    endtask

    task automatic push_word(input logic [31:0] w);
        img.push_back(w[7:0]);
        img.push_back(w[15:8]);
        img.push_back(w[23:16]);
        img.push_back(w[31:24]);
    endtask

    // Drives bytes from posedge+1; leaves the caller at posedge+1.
    task automatic send(input logic [7:0] q[$], input int max_gap);
        int gap;
        foreach (q[i]) begin
            gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            if (gap > 0) begin
                rx_valid = 1'b0;
                repeat (gap) @(posedge clk);
                #1;
            end
            rx_data  = q[i];
            rx_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        rx_valid = 1'b0;
    endtask

    task automatic do_reset();
        rx_valid = 1'b0;
        rstn = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    task automatic check_end(input string tag);
        @(negedge clk);
        chk({tag, "_done"}, 32'(load_done), 32'(exp_done));
        chk({tag, "_error"}, 32'(load_error), 32'(exp_err));
        chk({tag, "_words"}, words_loaded, exp_words);
        chk({tag, "_rx_ready"}, 32'(rx_ready), 32'(!(exp_done || exp_err)));
        @(negedge clk);
        chk({tag, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic run_image(input string tag, input int max_gap);
        do_reset();
        model(img);
        send(img, max_gap);
        check_end(tag);
    endtask

    initial begin
        logic [31:0] n, w, sum;
        int nx;
        rstn = 1'b0;
        rx_valid = 1'b0;
        rx_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        @(negedge clk);
        chk("rst_rx_ready", 32'(rx_ready), 32'd1);
        chk("rst_memwrite", 32'(memwrite), 32'd0);
        chk("rst_load_done", 32'(load_done), 32'd0);
        chk("rst_load_error", 32'(load_error), 32'd0);
        chk("rst_pro_addr", pro_addr, 32'd0);
        chk("rst_pro_data", pro_data, 32'd0);
        chk("rst_words_loaded", words_loaded, 32'd0);

        // Two-word image from the plan; good trailer when checksum is present.
        img.delete();
        push_word(32'd2);
        push_word(32'h0000_0013);
        push_word(32'h0010_0093);
        if (CSUM_EN) push_word(32'h0010_00A6);
        run_image("two_words", 0);
        $display("txn two_words: done=%0b error=%0b words=%0d", load_done, load_error, words_loaded);

        if (CSUM_EN) begin
            img.delete();
            push_word(32'd2);
            push_word(32'h0000_0013);
            push_word(32'h0010_0093);
            push_word(32'h0000_0000);
            run_image("bad_csum", 0);
            $display("txn bad_csum: done=%0b error=%0b", load_done, load_error);
        end

        // Count one above capacity, followed by bytes that must be ignored.
        img.delete();
        push_word(32'(MAX_W + 1));
        push_word(32'h1122_3344);
        push_word(32'h5566_7788);
        run_image("too_big", 0);
        $display("txn too_big: done=%0b error=%0b", load_done, load_error);

        // Reset in the middle of the second word, then a one-word image.
        img.delete();
        push_word(32'd3);
        push_word(32'h1234_5678);
        img.push_back(8'hAA);
        img.push_back(8'hBB);
        run_image("midrst_pre", 0);
        do_reset();
        @(negedge clk);
        chk("midrst_words_cleared", words_loaded, 32'd0);
        chk("midrst_rx_ready", 32'(rx_ready), 32'd1);
        @(posedge clk);
        #1;
        img.delete();
        push_word(32'd1);
        push_word(32'hDEAD_BEEF);
        if (CSUM_EN) push_word(32'hDEAD_BEEF);
        model(img);
        send(img, 0);
        check_end("midrst_post");
        $display("txn midrst: done=%0b words=%0d last=%h", load_done, words_loaded, pro_data);

        // Back-to-back bytes: four words, then extra bytes in a terminal state.
        img.delete();
        sum = 32'd0;
        push_word(32'd4);
        for (int i = 0; i < 4; i++) begin
            w = $urandom;
            sum = sum + w;
            push_word(w);
        end
        if (CSUM_EN) push_word(sum);
        for (int i = 0; i < 6; i++) img.push_back(8'($urandom));
        have_prev = 1'b0;
        spacing_en = 1'b1;
        run_image("b2b", 0);
        spacing_en = 1'b0;
        $display("txn b2b: done=%0b words=%0d", load_done, words_loaded);

        // Randomized images: sizes including zero, oversize counts,
        // corrupted trailers, idle gaps and trailing junk.
        for (int t = 0; t < 25; t++) begin
            img.delete();
            sum = 32'd0;
            n = 32'($urandom_range(6, 0));
            if ($urandom_range(7, 0) == 0) n = 32'(MAX_W + 1) + 32'($urandom_range(1000, 0));
            push_word(n);
            if (n <= 32'(MAX_W)) begin
                for (int i = 0; i < int'(n); i++) begin
                    w = $urandom;
                    sum = sum + w;
                    push_word(w);
                end
                if (CSUM_EN) begin
                    if ($urandom_range(2, 0) == 0) push_word(sum ^ (32'd1 << $urandom_range(31, 0)));
                    else push_word(sum);
                end
            end
            nx = int'($urandom_range(5, 0));
            for (int i = 0; i < nx; i++) img.push_back(8'($urandom));
            run_image("random", 2);
            $display("txn random %0d: n=%0d done=%0b error=%0b words=%0d", t, n, load_done, load_error, words_loaded);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
